// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a}, anode-off level and index-width helper.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h03;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic AN_OFF = 1'b1;

    // Digit index is at least one bit wide even for a single digit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Datapath-side bundle of the scan driver: BCD load/blank controls in,
// segment/anode/debug index out.
interface seven_seg_scan_if #(
    parameter int unsigned N_DIGITS = 4
);
    import seven_seg_pkg::*;

    localparam int unsigned IDX_W = idx_width(N_DIGITS);

    logic [4*N_DIGITS-1:0] bcd_in;
    logic                  load;
    logic                  blank;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic [IDX_W-1:0]      digit_idx;

    modport master (
        output bcd_in, load, blank,
        input  seg, an, digit_idx
    );

    modport slave (
        input  bcd_in, load, blank,
        output seg, an, digit_idx
    );

endinterface

// File: rtl/seven_seg_dec.sv
// Combinational BCD to active-low seven-segment decoder; nibbles 10..15 are dark.
module seven_seg_dec
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot dead time.
// Optional macro LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero one.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(N_DIGITS);
    localparam int unsigned PW    = $clog2(SCAN_DIV);

    logic [PW-1:0]         presc;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow;
    logic [3:0]            cur_digit;
    logic [6:0]            cur_seg;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  dead;
    logic                  lit;

    generate
        if (DEAD_CYCLES > 0) begin : g_dead
            assign dead = (presc < PW'(DEAD_CYCLES));
        end else begin : g_nodead
            assign dead = 1'b0;
        end
    endgenerate

    always_comb begin
        cur_digit = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k))
                cur_digit = shadow[4*k +: 4];
        end
    end

    seven_seg_dec u_dec (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Highest nonzero digit position; stays 0 for an all-zero shadow so digit 0 always lights.
    logic [IDX_W-1:0] msd;

    always_comb begin
        msd = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (shadow[4*k +: 4] != 4'd0)
                msd = IDX_W'(k);
        end
    end

    assign lit = (idx <= msd);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (!bus.blank && !dead && lit) begin
            seg_d = cur_seg;
            for (int unsigned k = 0; k < N_DIGITS; k++)
                an_d[k] = (idx == IDX_W'(k)) ? ~AN_OFF : AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            idx    <= '0;
            shadow <= '0;
            seg_q  <= SEG_BLANK;
            an_q   <= '1;
        end else begin
            if (bus.load)
                shadow <= bus.bcd_in;
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = idx;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised, time-multiplexed driver for N common-anode seven-segment digits sharing one active-low segment bus. Latches a packed BCD word on a load strobe and scans one digit per slot. Per-digit dead time suppresses ghosting; a blank input darkens the display. Sits between the datapath (counters, ALU results) and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (0..SCAN_DIV-1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
bcd_in  input  4*N_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k], digit 0 rightmost
load  input  1  1-cycle strobe: capture bcd_in into shadow register
blank  input  1  1 = all digits dark; scanning continues
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  N_DIGITS  anode enables, active-low, one-hot-low while lit
digit_idx  output  clog2(N_DIGITS) (min 1)  index of current slot (debug)

Behaviour:
- Reset (rst=1 at clk edge): seg=7'h7F, an=all ones, digit_idx=0, prescaler=0, shadow=0. Reset wins over load/blank in the same cycle; reset mid-scan restarts at slot 0, count 0.
- Prescaler: width clog2(SCAN_DIV); counts 0..SCAN_DIV-1, then wraps to 0 and advances digit_idx; digit_idx wraps N_DIGITS-1 -> 0.
- Shadow: on load=1, shadow <= bcd_in at that edge. bcd_in ignored otherwise. Load does not disturb prescaler/digit_idx.
- Decode per digit (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=03, 7=78, 8=00, 9=18 (hex); nibbles 10..15 -> 7F (dark).
- seg/an registered: value at edge t+1 derived from prescaler, digit_idx, shadow, blank at edge t (1-cycle latency).
- Dead time: while prescaler < DEAD_CYCLES, an=all ones, seg=7F. Otherwise an[digit_idx]=0, others 1; seg=decode(shadow digit digit_idx).
- blank=1: an=all ones, seg=7F from next edge; deassert resumes mid-slot with no re-sync.
- N_DIGITS=1: digit_idx constant 0; an[0] toggles only with dead time.
- Load in same cycle a slot starts: new value shown in that slot.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN. Defined: digits above the most significant nonzero shadow digit are dark (an bit stays 1, seg=7F); digit 0 is always lit (shadow 0 shows single "0"). Undefined: all N_DIGITS digits lit, including leading zeros.

Decomposition:
- Package seven_seg_pkg: segment pattern constants SEG_0..SEG_9, SEG_BLANK (7'h7F), active-low off constant.
- Sub-module seven_seg_dec: combinational 4-bit BCD -> 7-bit active-low decoder, using package constants; instantiated once on the muxed digit.
- Top seven_seg_scan holds prescaler, digit counter, shadow, output registers, leading-zero logic.

Test Plan:
(bench: N_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1)
- Reset: rst high 2 cycles -> seg=7F, an=4'b1111, digit_idx=0; after release first lit cycle at count 1: an=4'b1110.
- load bcd_in=16'h1234 -> over 16 cycles an sequence 1110,1101,1011,0111 with seg 19,30,24,79, each slot preceded by 1 dead cycle (an=1111, seg=7F).
- Invalid nibble: load 16'h00A5 -> digit 1 slot seg=7F, digit 0 slot seg=12.
- blank=1 mid-slot -> next edge an=1111, seg=7F; digit_idx keeps advancing every 4 cycles; release resumes mid-slot.
- rst asserted mid-slot 2 with load=1 same cycle -> shadow=0, digit_idx=0, outputs dark.
- LEADING_ZERO_BLANK_EN defined, load 16'h0070 -> digits 3,2 dark, digit 1 seg=78, digit 0 seg=40; load 16'h0000 -> only digit 0 lit, seg=40.
